// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and widths.
package div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_ITERS = DIV_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } divState_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             dividendMsb,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] remNext,
   output logic             qBit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // rem < divisor holds between steps, so one extra bit is enough to see the borrow.
   always_comb begin
      shifted = {rem, dividendMsb};
      trial   = shifted - {1'b0, divisor};
      qBit    = ~trial[WIDTH];
      remNext = qBit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) for the EX stage.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations.
module div_iter
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             annul_i,
   output logic             div_running,
   output logic             ready_o,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] hi_o,
   output divState_t        dbgState
);

   // Handshake: start_i is a level request accepted only in IDLE (unless annul_i);
   // div_running is the stall the pipeline obeys; ready_o pulses one cycle in DONE
   // and lo_o/hi_o are valid in that same cycle.

   divState_t        state, stateNext;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] remQ, quoQ, divisorQ, loQ, hiQ;
   logic [WIDTH-1:0] aAbs, bAbs, stepRem, loFix, hiFix;
   logic             signQ, signR, stepBit, lastStep, zeroFast;

`ifdef DIV_ZERO_FAST_EN
   assign zeroFast = (b_i == '0);
`else
   assign zeroFast = 1'b0;
`endif

   assign aAbs     = (signed_i & a_i[WIDTH-1]) ? -a_i : a_i;
   assign bAbs     = (signed_i & b_i[WIDTH-1]) ? -b_i : b_i;
   assign lastStep = (cnt == CNT_W'(WIDTH - 1));
   assign loFix    = signQ ? -quoQ : quoQ;
   assign hiFix    = signR ? -remQ : remQ;
   assign dbgState = state;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem        (remQ),
      .dividendMsb(quoQ[WIDTH-1]),
      .divisor    (divisorQ),
      .remNext    (stepRem),
      .qBit       (stepBit)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= stateNext;
   end

   always_comb begin
      stateNext   = state;
      div_running = 1'b0;
      ready_o     = 1'b0;
      case (state)
         IDLE: begin
            div_running = start_i & ~annul_i;
            if (start_i & ~annul_i) stateNext = zeroFast ? DONE : BUSY;
         end
         BUSY: begin
            div_running = ~annul_i;
            if (annul_i)       stateNext = IDLE;
            else if (lastStep) stateNext = DONE;
         end
         DONE: begin
            ready_o   = ~annul_i;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Results are shown combinationally during the ready pulse, then held in loQ/hiQ.
   assign lo_o = ready_o ? loFix : loQ;
   assign hi_o = ready_o ? hiFix : hiQ;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt      <= '0;
         remQ     <= '0;
         quoQ     <= '0;
         divisorQ <= '0;
         signQ    <= 1'b0;
         signR    <= 1'b0;
         loQ      <= '0;
         hiQ      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i & ~annul_i) begin
                  divisorQ <= bAbs;
                  signQ    <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                  signR    <= signed_i & a_i[WIDTH-1];
                  cnt      <= '0;
                  // Zero-divisor shortcut loads the natural restoring result directly.
                  if (zeroFast) begin
                     quoQ <= '1;
                     remQ <= aAbs;
                  end else begin
                     quoQ <= aAbs;
                     remQ <= '0;
                  end
               end
            end
            BUSY: begin
               if (!annul_i) begin
                  remQ <= stepRem;
                  quoQ <= {quoQ[WIDTH-2:0], stepBit};
                  cnt  <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               if (ready_o) begin
                  loQ <= loFix;
                  hiQ <= hiFix;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases plus randomized operands
// compared against a plain-arithmetic reference model.
module tb_div_iter;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start_i = 1'b0;
   logic        signed_i = 1'b0;
   logic [31:0] a_i = '0;
   logic [31:0] b_i = '0;
   logic        annul_i = 1'b0;
   logic        div_running, ready_o;
   logic [31:0] lo_o, hi_o;
   logic [1:0]  dbgState;

   int checks = 0;
   int errors = 0;
   logic [31:0] expQ[$];
   logic [31:0] lastLo = '0;
   logic [31:0] lastHi = '0;

   div_iter dut (
      .clk        (clk),
      .resetn     (resetn),
      .start_i    (start_i),
      .signed_i   (signed_i),
      .a_i        (a_i),
      .b_i        (b_i),
      .annul_i    (annul_i),
      .div_running(div_running),
      .ready_o    (ready_o),
      .lo_o       (lo_o),
      .hi_o       (hi_o),
      .dbgState   (dbgState)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Reference: architectural DIV/DIVU with truncating division, no-trap divide by zero.
   task automatic refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eLo, output logic [31:0] eHi);
      longint sa, sb;
      if (b == 0) begin
         eLo = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
         eHi = a;
      end else if (sgn) begin
         sa  = longint'($signed(a));
         sb  = longint'($signed(b));
         eLo = 32'(sa / sb);
         eHi = 32'(sa % sb);
      end else begin
         eLo = a / b;
         eHi = a % b;
      end
   endtask

   function automatic int expRunCycles(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
      return (b == 0) ? 1 : 33;
`else
      return 33;
`endif
   endfunction

   task automatic runDiv(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int holdCycles);
      logic [31:0] eLo, eHi, xLo, xHi;
      int runCnt, rdyCnt, rdyAt, expRun;
      refDiv(sgn, a, b, eLo, eHi);
      expQ.push_back(eLo);
      expQ.push_back(eHi);
      expRun = expRunCycles(b);
      runCnt = 0; rdyCnt = 0; rdyAt = 0;
      @(posedge clk); #1;
      start_i = 1'b1; signed_i = sgn; a_i = a; b_i = b;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (div_running) runCnt++;
         if (ready_o) begin
            rdyCnt++;
            if (rdyCnt == 1 && expQ.size() >= 2) begin
               rdyAt = c;
               xLo = expQ.pop_front();
               xHi = expQ.pop_front();
               checkVal({tag, ".lo"}, lo_o, xLo);
               checkVal({tag, ".hi"}, hi_o, xHi);
            end
         end
         @(posedge clk); #1;
         if (c >= holdCycles) start_i = 1'b0;
      end
      while (expQ.size() > 0) void'(expQ.pop_front());
      checkVal({tag, ".readyCount"}, 32'(rdyCnt), 32'd1);
      checkVal({tag, ".readyCycle"}, 32'(rdyAt), 32'(expRun + 1));
      checkVal({tag, ".runCycles"}, 32'(runCnt), 32'(expRun));
      @(negedge clk);
      checkVal({tag, ".loHold"}, lo_o, eLo);
      checkVal({tag, ".hiHold"}, hi_o, eHi);
      lastLo = eLo;
      lastHi = eHi;
   endtask

   task automatic annulTest();
      int rdyCnt;
      rdyCnt = 0;
      for (int c = 1; c <= 45; c++) begin
         @(posedge clk); #1;
         start_i  = (c == 1);
         signed_i = 1'b0; a_i = 32'd1000; b_i = 32'd3;
         annul_i  = (c == 11);
         @(negedge clk);
         if (ready_o) rdyCnt++;
         if (c == 11) checkVal("annul.runningLow", 32'(div_running), 32'd0);
         if (c == 12) begin
            checkVal("annul.idleNext", 32'(dbgState), 32'd0);
            checkVal("annul.runningIdle", 32'(div_running), 32'd0);
         end
      end
      checkVal("annul.noReady", 32'(rdyCnt), 32'd0);
      checkVal("annul.loKept", lo_o, lastLo);
      checkVal("annul.hiKept", hi_o, lastHi);
   endtask

   task automatic midResetTest();
      int rdyCnt;
      rdyCnt = 0;
      for (int c = 1; c <= 21; c++) begin
         @(posedge clk); #1;
         start_i = (c == 1); signed_i = 1'b1; a_i = 32'hFFFF_FF00; b_i = 32'd7;
      end
      #2 resetn = 1'b0;
      #1;
      checkVal("rstMid.lo", lo_o, 32'd0);
      checkVal("rstMid.hi", hi_o, 32'd0);
      checkVal("rstMid.ready", 32'(ready_o), 32'd0);
      checkVal("rstMid.running", 32'(div_running), 32'd0);
      checkVal("rstMid.state", 32'(dbgState), 32'd0);
      @(negedge clk); #1 resetn = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ready_o) rdyCnt++;
      end
      checkVal("rstMid.noReady", 32'(rdyCnt), 32'd0);
      lastLo = '0;
      lastHi = '0;
   endtask

   initial begin
      logic        sgn;
      logic [31:0] ra, rb;
      repeat (3) @(negedge clk);
      checkVal("reset.lo", lo_o, 32'd0);
      checkVal("reset.hi", hi_o, 32'd0);
      checkVal("reset.ready", 32'(ready_o), 32'd0);
      checkVal("reset.running", 32'(div_running), 32'd0);
      checkVal("reset.state", 32'(dbgState), 32'd0);
      #1 resetn = 1'b1;

      runDiv("divu100_7", 1'b0, 32'd100, 32'd7, 1);
      runDiv("divNeg7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1);
      runDiv("div7_neg2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1);
      runDiv("divOvf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
      runDiv("divu5_0", 1'b0, 32'd5, 32'd0, 1);
      runDiv("divNeg5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 1);
      annulTest();
      runDiv("afterAnnul", 1'b1, 32'd12345, 32'hFFFF_FFF0, 1);
      runDiv("holdStart", 1'b0, 32'hDEAD_BEEF, 32'd77, 34);
      midResetTest();
      runDiv("afterReset", 1'b0, 32'd999, 32'd10, 1);

      for (int i = 0; i < 24; i++) begin
         sgn = 1'($urandom_range(0, 1));
         ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 4))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         runDiv($sformatf("rand%0d", i), sgn, ra, rb, 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout got=0x%08h exp=0x%08h", checks, 32'd0);
      $fatal(1, "simulation time limit reached");
   end

endmodule
